// File: rtl/cart_dongle_prober_if.sv
// Request/response and cartridge-port signals between the diagnostic controller,
// the dongle prober and the dongle on the ROM3 window.
interface cart_dongle_prober_if #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = 6
);
    logic                start;
    logic [LEN_W-1:0]    len;
    logic [MAX_BITS-1:0] challenge;
    logic                busy;
    logic                done;
    logic [MAX_BITS-1:0] response;
    logic                rom3_n;
    logic                a8;
    logic                d8;

    // The master side is the controller together with the dongle it exercises.
    modport master (
        output start, len, challenge, d8,
        input  busy, done, response, rom3_n, a8
    );

    modport slave (
        input  start, len, challenge, d8,
        output busy, done, response, rom3_n, a8
    );
endinterface

// File: rtl/cart_dongle_prober.sv
// Dongle challenge/response initiator: strobes rom3_n, shifts the challenge out on a8
// and collects d8 replies. Define DONGLE_PROBER_SYNC_EN to synchronise d8 for an external dongle.
module cart_dongle_prober #(
    parameter int MAX_BITS    = 32,
    parameter int LEN_W       = 6,
    parameter int LOW_CYCLES  = 4,
    parameter int HIGH_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cart_dongle_prober_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CNT_MAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_last;
    logic [MAX_BITS-1:0] r_chal;
    logic [MAX_BITS-1:0] r_resp;
    logic                r_busy;
    logic                r_done;
    logic                r_rom3_n;
    logic                r_a8;
    logic                w_d8;
    logic [LEN_W-1:0]    w_eff_len;

    if (LOW_CYCLES < 1) begin : g_low_chk
        $error("cart_dongle_prober: LOW_CYCLES must be at least 1");
    end
    if (HIGH_CYCLES < 3) begin : g_high_chk
        $error("cart_dongle_prober: HIGH_CYCLES must be at least 3");
    end
    if (MAX_BITS >= (2 ** LEN_W)) begin : g_len_chk
        $error("cart_dongle_prober: LEN_W too narrow for MAX_BITS");
    end

`ifdef DONGLE_PROBER_SYNC_EN
    logic [1:0] r_d8_sync;

    if (HIGH_CYCLES < 5) begin : g_sync_chk
        $error("cart_dongle_prober: HIGH_CYCLES must be at least 5 with d8 synchroniser");
    end

    // Two-flop synchroniser for the asynchronous external d8 line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d8_sync <= 2'b00;
        end else begin
            r_d8_sync <= {r_d8_sync[0], bus.d8};
        end
    end
    assign w_d8 = r_d8_sync[1];
`else
    assign w_d8 = bus.d8;
`endif

    assign w_eff_len = (bus.len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : bus.len;

    // Burst sequencer; every output is driven from a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_last   <= {IDX_W{1'b0}};
            r_chal   <= {MAX_BITS{1'b0}};
            r_resp   <= {MAX_BITS{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rom3_n <= 1'b1;
            r_a8     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_chal <= bus.challenge;
                        r_resp <= {MAX_BITS{1'b0}};
                        r_idx  <= {IDX_W{1'b0}};
                        r_cnt  <= {CNT_W{1'b0}};
                        r_last <= IDX_W'(w_eff_len - LEN_W'(1));
                        if (w_eff_len == {LEN_W{1'b0}}) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= ST_LOW;
                            r_busy   <= 1'b1;
                            r_rom3_n <= 1'b0;
                            r_a8     <= bus.challenge[0];
                        end
                    end
                end
                ST_LOW: begin
                    if (r_cnt == CNT_W'(LOW_CYCLES - 1)) begin
                        r_cnt    <= {CNT_W{1'b0}};
                        r_rom3_n <= 1'b1;
                        r_state  <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == CNT_W'(HIGH_CYCLES - 1)) begin
                        r_cnt         <= {CNT_W{1'b0}};
                        r_resp[r_idx] <= w_d8;
                        if (r_idx == r_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_a8    <= 1'b0;
                        end else begin
                            // a8 moves only together with the falling edge of the next strobe.
                            r_idx    <= r_idx + IDX_W'(1);
                            r_rom3_n <= 1'b0;
                            r_a8     <= r_chal[r_idx + IDX_W'(1)];
                            r_state  <= ST_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_rom3_n <= 1'b1;
                    r_a8     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.response = r_resp;
    assign bus.rom3_n   = r_rom3_n;
    assign bus.a8       = r_a8;
endmodule

// File: doc/cart_dongle_prober.md
# cart_dongle_prober

Initiator for the ST cartridge-port dongle protocol. It issues a burst of ROM3 strobes on `rom3_n`, presents one challenge bit per strobe on `a8`, and captures the dongle's `d8` reply after each strobe into a response word. It sits beside the cartridge-port mux and is used by the test/diagnostic controller to exercise either the on-chip dongle emulation or a physical dongle on the external cartridge connector.

## Interface
- `MAX_BITS`, 32: challenge/response word width; maximum burst length.
- `LEN_W`, 6: width of `len`; must hold `MAX_BITS`.
- `LOW_CYCLES`, 4: clk cycles `rom3_n` is held low per strobe; minimum 1.
- `HIGH_CYCLES`, 4: clk cycles `rom3_n` is held high per strobe, including the sample cycle; minimum 3.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `len`  in  LEN_W  number of strobes; captured at accept.
- `challenge`  in  MAX_BITS  A8 bit pattern; captured at accept; bit 0 is sent first.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse when the burst completes.
- `response`  out  MAX_BITS  captured D8 bits; `response[i]` is the reply to strobe i.
- `rom3_n`  out  1  ROM3 select to the dongle, active low.
- `a8`  out  1  address bit 8 to the dongle.
- `d8`  in  1  data bit 8 from the dongle.

## Operation
- FSM states are IDLE, LOW, HIGH and DONE. All outputs are registered.
- **Reset values:** `rom3_n`=1, `a8`=0, `busy`=0, `done`=0, `response`=0. FSM goes to IDLE; counters are cleared.
- **IDLE:**
  - When `start`=1, capture `challenge`. Capture `len`, clamped to `MAX_BITS` if larger.
  - Clear `response` and the bit index i.
  - If the effective len is 0, go to DONE. Otherwise go to LOW.
- **LOW:**
  - `rom3_n`=0 and `a8`=challenge[i], held for `LOW_CYCLES` cycles, then go to HIGH.
- **HIGH:**
  - `rom3_n`=1 and `a8` still holds challenge[i], held for `HIGH_CYCLES` cycles.
  - On the last HIGH cycle, latch `response[i]` from the D8 sample.
  - If i == len-1, go to DONE. Otherwise increment i and go to LOW.
- **DONE:**
  - `done`=1 and `busy`=0 for one cycle, `a8`=0, then go to IDLE.
  - `response` holds until the next accepted `start` or reset.
- `start` is ignored in LOW, HIGH and DONE; it is not queued.
- Bits of `response` at index ≥ len stay 0.
- **Reset mid-burst:** `rom3_n` returns high at the next edge and no `done` is generated. A LOW→high transition caused by reset still clocks the dongle once. Callers must reset the dongle as well, or re-synchronise it, before relying on its state.

## Timing
- `start` is sampled at edge E0.
- `busy`=1 from cycle 1 through cycle len×(L+H), where L=`LOW_CYCLES` and H=`HIGH_CYCLES`.
- For strobe i, `rom3_n` is low in cycles i×(L+H)+1 through i×(L+H)+L.
- For strobe i, `response[i]` is latched at the edge ending cycle (i+1)×(L+H).
- `done`=1 in cycle len×(L+H)+1. For len=0, `done`=1 in cycle 1 and `busy` never rises.
- Back-to-back bursts: the earliest next `start` is accepted in the cycle after `done`.
- `a8` changes only in the first LOW cycle of a strobe, or at DONE/reset. It is therefore stable for ≥ H cycles after the rising edge of `rom3_n`, so the dongle sees a stable A8 on its rising-edge detect.
- The dongle updates D8 within 2 clk cycles of the rising edge of `rom3_n`. The sample point on the last HIGH cycle, with H≥3 (or H≥5 when sync is enabled), covers this.

## Configuration
- `DONGLE_PROBER_SYNC_EN`
  - **Defined:** `d8` passes through a two-flop synchroniser (reset to 0) before sampling, for a physical dongle on the external connector. `HIGH_CYCLES` must be ≥5; elaboration fails otherwise.
  - **Undefined:** `d8` is sampled directly, which is valid only for the on-chip, same-clock dongle. `HIGH_CYCLES` must be ≥3.

## Test plan
- **Echo dongle** (d8 <= a8 on each `rom3_n` rise), len=8, challenge=0xA5, default L=H=4 → `response`=0x000000A5, `done` in cycle 65, exactly 8 `rom3_n` falling edges.
- **Constant dongle**, d8 tied 1, len=32 → `response`=0xFFFFFFFF. Then d8 tied 0, len=5 → `response`=0.
- **len edge cases:**
  - len=0 → `done` in cycle 1, `rom3_n` never low, `response`=0.
  - len=40 → clamped to 32 strobes.
- **`start` pulsed while busy** at cycles 3 and 20 → ignored; a single `done`, and the strobe count equals len.
- **Reset mid-burst:** reset asserted in cycle 10 of a len=8 burst → next cycle has `rom3_n`=1, `busy`=0, `response`=0, and no `done`. A new `start` then runs a clean burst.
- **Sync enabled**, echo dongle with a 1-cycle output delay, H=5, len=16, challenge=0x3C5A → `response`=0x3C5A.
